tv_recorder: RTL and testbench
==============================

# tv_recorder

Synthesizable test-vector writer: captures stimulus/response pairs from a DUT on the lab board into an on-chip buffer, in the same `{inputs, expected outputs}` bit order our `.tv` files use. It then streams them out over a valid/ready read port so they can be dumped to a host and replayed by the self-checking benches. It sits between the board-level DUT wrapper and the UART/debug readout logic.

## Interface
Parameters:
- `IN_W`, 7, DUT input bits per vector
- `OUT_W`, 3, DUT output bits per vector
- `DEPTH`, 16, vector slots; power of two, ≥ 2
- `VEC_W` (localparam) = `IN_W + OUT_W`
- `CW` (localparam) = `$clog2(DEPTH) + 1`

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low (0 = reset)
- `arm`  in  1  pulse: clear buffer and start capture
- `dump`  in  1  pulse: start readout of captured vectors
- `cap_valid`  in  1  a vector is presented on `cap_in`/`cap_out`
- `cap_in`  in  IN_W  DUT input word
- `cap_out`  in  OUT_W  DUT output word
- `cap_ready`  out  1  vector accepted this cycle if `cap_valid`
- `rd_valid`  out  1  `rd_data` holds a stored vector
- `rd_data`  out  VEC_W  `{cap_in, cap_out}`, MSB first
- `rd_ready`  in  1  consumer accepts `rd_data`
- `rd_last`  out  1  current `rd_data` is the final stored vector
- `count`  out  CW  vectors stored, 0..DEPTH
- `full`  out  1  `count == DEPTH`
- `overflow`  out  1  sticky: a vector was dropped while full

## Operation
- FSM states: IDLE, CAPTURE, DUMP. Reset state is IDLE.
- IDLE:
  - `arm` → CAPTURE; clears `count`, write pointer and `overflow`.
  - `dump` with `count > 0` → DUMP; read pointer set to 0.
  - `dump` with `count == 0` is ignored.
  - If `arm` and `dump` arrive together: `dump` wins when `count > 0`, otherwise `arm` wins.
- CAPTURE:
  - `cap_ready = !full`.
  - On `cap_valid && cap_ready`, write `{cap_in, cap_out}` to slot `count` and increment `count`.
  - On `cap_valid` while `full`: the vector is dropped and `overflow` is set.
  - `dump` with `count > 0` → DUMP; a capture handshake in the same cycle is still stored.
  - `dump` with `count == 0` is ignored.
  - `arm` restarts capture: clears the buffer again.
- DUMP:
  - `rd_valid = 1`; `rd_data = mem[rd_ptr]`; `rd_last = (rd_ptr == count-1)`.
  - On `rd_valid && rd_ready`: `rd_ptr` increments.
  - On a handshake with `rd_last`: → IDLE.
  - `arm`, `dump` and `cap_valid` are ignored; `cap_ready = 0`.
- Captured data and `count` are retained after DUMP, so a repeated `dump` replays the same vectors.
- Outside DUMP: `rd_valid = 0`, `rd_last = 0`, and `rd_data` is forced to 0.

## Timing
- Reset values of all outputs: `cap_ready` 0, `rd_valid` 0, `rd_data` 0, `rd_last` 0, `count` 0, `full` 0, `overflow` 0. Memory contents are not reset.
- Capture latency: a vector accepted at edge N is reflected in `count` after edge N.
- Capture throughput: one vector per cycle.
- Readout:
  - `rd_valid` rises the cycle after `dump` is sampled.
  - One vector per cycle while `rd_ready` is held high.
  - While `rd_valid && !rd_ready`, `rd_data` and `rd_last` stay stable.
- `rd_valid` falls the cycle after the last handshake.
- `full` and `overflow` are registered; `overflow` updates one edge after the drop.
- Asserting `reset` mid-capture or mid-dump aborts immediately: all outputs go to reset values and `count` becomes 0.

## Structure
- Package `tv_pkg`:
  - `tv_state_t` enum {IDLE, CAPTURE, DUMP}
  - default width constants `TV_IN_W = 7`, `TV_OUT_W = 3`
- Sub-module `tv_mem`: DEPTH×VEC_W register file with synchronous write and asynchronous read, no reset.
- Top level: FSM, pointers, flags.

## Test plan
- Reset, `arm`, capture 3 vectors (`7'b1010101/3'b110`, `7'b0000001/3'b001`, `7'b1111111/3'b000`), then `dump` with `rd_ready = 1`:
  - `count = 3`
  - `rd_data` = `10'b1010101110`, `10'b0000001001`, `10'b1111111000` on consecutive cycles
  - `rd_last` set on the third only; back to IDLE.
- Capture 17 vectors with DEPTH = 16:
  - `full = 1` and `cap_ready = 0` after the 16th
  - 17th dropped; `overflow = 1`; `count = 16`
  - dump yields exactly 16 vectors.
- Backpressure: during dump, hold `rd_ready = 0` for 3 cycles on vector 2 → `rd_data` is unchanged and no vector is skipped or repeated.
- `dump` with `count = 0`: no `rd_valid`, state stays IDLE. Simultaneous `arm` + `dump` with `count = 2` → DUMP, 2 vectors read out.
- Drive `reset = 0` mid-dump after vector 1 → `rd_valid = 0` and `count = 0` immediately. After release, `dump` is ignored.
- Repeat `dump` after a completed dump → identical vector sequence is replayed.

Source files
------------

// File: rtl/tv_pkg.sv
// tv_pkg: shared types and default widths for the test-vector recorder.
//   tv_state_t : recorder FSM state
//   TV_IN_W    : default DUT input bits per vector
//   TV_OUT_W   : default DUT output bits per vector
package tv_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DUMP    = 2'd2
  } tv_state_t;

  localparam int unsigned TV_IN_W  = 7;
  localparam int unsigned TV_OUT_W = 3;

endpackage

// File: rtl/tv_mem.sv
// tv_mem: DEPTH x VEC_W register file, synchronous write, asynchronous read, no reset.
// Ports:
//   clk     : write clock
//   i_we    : write enable
//   i_waddr : write slot
//   i_wdata : write word
//   i_raddr : read slot
//   o_rdata : read word (combinational)
module tv_mem #(
  parameter int unsigned VEC_W = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [VEC_W-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [VEC_W-1:0]         o_rdata
);

  logic [VEC_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/tv_recorder.sv
// tv_recorder: captures {cap_in, cap_out} vectors into a buffer and streams them out
// over a valid/ready read port.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   arm, dump    : pulses to start capture / start readout
//   cap_valid, cap_in, cap_out, cap_ready : capture handshake
//   rd_valid, rd_data, rd_ready, rd_last  : readout handshake
//   count, full, overflow                 : buffer status
module tv_recorder
  import tv_pkg::*;
#(
  parameter int unsigned IN_W  = TV_IN_W,
  parameter int unsigned OUT_W = TV_OUT_W,
  parameter int unsigned DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      arm,
  input  logic                      dump,
  input  logic                      cap_valid,
  input  logic [IN_W-1:0]           cap_in,
  input  logic [OUT_W-1:0]          cap_out,
  output logic                      cap_ready,
  output logic                      rd_valid,
  output logic [IN_W+OUT_W-1:0]     rd_data,
  input  logic                      rd_ready,
  output logic                      rd_last,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      overflow
);

  localparam int unsigned VEC_W = IN_W + OUT_W;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  tv_state_t     r_state;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_rd_ptr;
  logic          r_overflow;

  logic             w_full;
  logic             w_last;
  logic             w_dump_go;
  logic             w_arm_go;
  logic             w_wr_en;
  logic             w_drop;
  logic [VEC_W-1:0] w_rdata;

  assign w_full = (r_count == FULL_CNT);
  assign w_last = ({1'b0, r_rd_ptr} == (r_count - CW'(1)));

  // dump beats arm whenever there is something to read; both are ignored in DUMP
  assign w_dump_go = (r_state != DUMP) && dump && (r_count != '0);
  assign w_arm_go  = (r_state != DUMP) && arm && !w_dump_go;

  // an arm restart discards any vector presented in the same cycle
  assign w_wr_en = (r_state == CAPTURE) && cap_valid && !w_full && !w_arm_go;
  assign w_drop  = (r_state == CAPTURE) && cap_valid && w_full && !w_arm_go;

  tv_mem #(
    .VEC_W (VEC_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (r_count[AW-1:0]),
    .i_wdata ({cap_in, cap_out}),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE, CAPTURE: begin
          if (w_wr_en) r_count <= r_count + CW'(1);
          if (w_drop)  r_overflow <= 1'b1;
          if (w_dump_go) begin
            r_state  <= DUMP;
            r_rd_ptr <= '0;
          end else if (w_arm_go) begin
            r_state    <= CAPTURE;
            r_count    <= '0;
            r_overflow <= 1'b0;
          end
        end
        DUMP: begin
          if (rd_ready) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_last) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cap_ready = (r_state == CAPTURE) && !w_full;
  assign rd_valid  = (r_state == DUMP);
  assign rd_data   = rd_valid ? w_rdata : '0;
  assign rd_last   = rd_valid && w_last;
  assign count     = r_count;
  assign full      = w_full;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_tv_recorder.sv
// Bench for tv_recorder: directed scenarios with literal expectations plus a randomized
// phase, all outputs compared every cycle against a queue-based model of the recorder.
module tb_tv_recorder;

  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       arm = 1'b0;
  logic       dump = 1'b0;
  logic       cap_valid = 1'b0;
  logic [6:0] cap_in = '0;
  logic [2:0] cap_out = '0;
  logic       rd_ready = 1'b0;
  logic       cap_ready;
  logic       rd_valid;
  logic [9:0] rd_data;
  logic       rd_last;
  logic [4:0] count;
  logic       full;
  logic       overflow;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  tv_recorder #(
    .IN_W  (7),
    .OUT_W (3),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .arm       (arm),
    .dump      (dump),
    .cap_valid (cap_valid),
    .cap_in    (cap_in),
    .cap_out   (cap_out),
    .cap_ready (cap_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_ready  (rd_ready),
    .rd_last   (rd_last),
    .count     (count),
    .full      (full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: stored vectors in a queue, plus capture/dump flags and a read index.
  logic [9:0] m_q[$];
  bit         m_cap = 1'b0;
  bit         m_dump = 1'b0;
  bit         m_ovf = 1'b0;
  int         m_idx = 0;
  bit         m_dump_go;

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_q.delete();
        m_cap = 1'b0;
        m_dump = 1'b0;
        m_ovf = 1'b0;
        m_idx = 0;
      end else if (m_dump) begin
        if (rd_ready) begin
          m_idx++;
          if (m_idx == m_q.size()) m_dump = 1'b0;
        end
      end else begin
        m_dump_go = dump && (m_q.size() > 0);
        if (arm && !m_dump_go) begin
          m_q.delete();
          m_ovf = 1'b0;
          m_cap = 1'b1;
        end else if (m_cap && cap_valid) begin
          if (m_q.size() < DEPTH) m_q.push_back({cap_in, cap_out});
          else m_ovf = 1'b1;
        end
        if (m_dump_go) begin
          m_dump = 1'b1;
          m_cap = 1'b0;
          m_idx = 0;
        end
      end
    end
  end

  logic [9:0] exp_data;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        exp_data = m_dump ? m_q[m_idx] : 10'd0;
        check("m_cap_ready", {31'd0, cap_ready},
              {31'd0, m_cap && !m_dump && (m_q.size() < DEPTH)});
        check("m_rd_valid", {31'd0, rd_valid}, {31'd0, m_dump});
        check("m_rd_data", {22'd0, rd_data}, {22'd0, exp_data});
        check("m_rd_last", {31'd0, rd_last}, {31'd0, m_dump && (m_idx == m_q.size() - 1)});
        check("m_count", {27'd0, count}, m_q.size());
        check("m_full", {31'd0, full}, {31'd0, m_q.size() == DEPTH});
        check("m_overflow", {31'd0, overflow}, {31'd0, m_ovf});
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic cap(input logic [6:0] i, input logic [2:0] o);
    cap_valid = 1'b1;
    cap_in = i;
    cap_out = o;
    step();
    cap_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  logic [9:0] e1 [3] = '{10'h2AE, 10'h009, 10'h3F8};
  logic [9:0] e3 [4] = '{10'h089, 10'h112, 10'h19B, 10'h224};
  int n_rd;
  int r;

  initial begin
    do_reset();
    chk_en = 1'b1;
    check("rst_cap_ready", {31'd0, cap_ready}, 0);
    check("rst_rd_valid", {31'd0, rd_valid}, 0);
    check("rst_rd_data", {22'd0, rd_data}, 0);
    check("rst_rd_last", {31'd0, rd_last}, 0);
    check("rst_count", {27'd0, count}, 0);
    check("rst_full", {31'd0, full}, 0);
    check("rst_overflow", {31'd0, overflow}, 0);

    // Basic capture of three vectors, then two identical dumps.
    do_arm();
    check("t1_cap_ready", {31'd0, cap_ready}, 1);
    cap(7'b1010101, 3'b110);
    cap(7'b0000001, 3'b001);
    cap(7'b1111111, 3'b000);
    check("t1_count", {27'd0, count}, 3);
    rd_ready = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      dump = 1'b1;
      step();
      dump = 1'b0;
      for (int k = 0; k < 3; k++) begin
        check("t1_rd_valid", {31'd0, rd_valid}, 1);
        check("t1_rd_data", {22'd0, rd_data}, {22'd0, e1[k]});
        check("t1_rd_last", {31'd0, rd_last}, (k == 2) ? 1 : 0);
        step();
      end
      check("t1_rd_done", {31'd0, rd_valid}, 0);
      check("t1_count_kept", {27'd0, count}, 3);
    end

    // Fill past capacity.
    do_arm();
    for (int k = 0; k < 17; k++) begin
      cap(7'($urandom), 3'($urandom));
      if (k == 15) begin
        check("t2_full", {31'd0, full}, 1);
        check("t2_cap_ready", {31'd0, cap_ready}, 0);
        check("t2_ovf_early", {31'd0, overflow}, 0);
      end
    end
    check("t2_overflow", {31'd0, overflow}, 1);
    check("t2_count", {27'd0, count}, 16);
    dump = 1'b1;
    step();
    dump = 1'b0;
    n_rd = 0;
    for (int k = 0; k < 40; k++) begin
      if (rd_valid) n_rd++;
      step();
    end
    check("t2_n_read", n_rd, 16);

    // Backpressure on the second vector.
    do_arm();
    for (int k = 0; k < 4; k++) cap(7'(8'h11 * (k + 1)), 3'(k + 1));
    dump = 1'b1;
    step();
    dump = 1'b0;
    check("t3_v1", {22'd0, rd_data}, {22'd0, e3[0]});
    step();
    check("t3_v2", {22'd0, rd_data}, {22'd0, e3[1]});
    rd_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t3_hold_data", {22'd0, rd_data}, {22'd0, e3[1]});
      check("t3_hold_last", {31'd0, rd_last}, 0);
    end
    rd_ready = 1'b1;
    step();
    check("t3_v3", {22'd0, rd_data}, {22'd0, e3[2]});
    step();
    check("t3_v4", {22'd0, rd_data}, {22'd0, e3[3]});
    check("t3_last", {31'd0, rd_last}, 1);
    step();
    check("t3_done", {31'd0, rd_valid}, 0);

    // Empty dump is ignored; arm+dump with data selects dump.
    do_reset();
    dump = 1'b1;
    step();
    dump = 1'b0;
    check("t4_empty_dump", {31'd0, rd_valid}, 0);
    do_arm();
    cap(7'h11, 3'h1);
    cap(7'h22, 3'h2);
    arm = 1'b1;
    dump = 1'b1;
    step();
    arm = 1'b0;
    dump = 1'b0;
    check("t4_rd_valid", {31'd0, rd_valid}, 1);
    check("t4_count", {27'd0, count}, 2);
    check("t4_v1", {22'd0, rd_data}, {22'd0, e3[0]});
    step();
    check("t4_v2", {22'd0, rd_data}, {22'd0, e3[1]});
    check("t4_last", {31'd0, rd_last}, 1);
    step();
    check("t4_done", {31'd0, rd_valid}, 0);

    // Reset in the middle of a dump.
    do_arm();
    cap(7'b1010101, 3'b110);
    cap(7'b0000001, 3'b001);
    cap(7'b1111111, 3'b000);
    dump = 1'b1;
    step();
    dump = 1'b0;
    step();
    check("t5_pre_v2", {22'd0, rd_data}, {22'd0, e1[1]});
    reset = 1'b0;
    #1;
    check("t5_rd_valid", {31'd0, rd_valid}, 0);
    check("t5_count", {27'd0, count}, 0);
    check("t5_rd_data", {22'd0, rd_data}, 0);
    step();
    reset = 1'b1;
    step();
    dump = 1'b1;
    step();
    dump = 1'b0;
    check("t5_dump_ignored", {31'd0, rd_valid}, 0);

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      r = $urandom_range(0, 99);
      arm = (r < 3);
      dump = (r >= 3) && (r < 7);
      cap_valid = !arm && ($urandom_range(0, 1) == 1);
      cap_in = 7'($urandom);
      cap_out = 3'($urandom);
      rd_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 599) != 0);
      step();
    end
    arm = 1'b0;
    dump = 1'b0;
    cap_valid = 1'b0;
    reset = 1'b1;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
